// File: rtl/parking_ctrl_sched.sv
// Parking occupancy controller: a lot shared between a university pool and a general pool.
// The uni share follows a time-of-day schedule. Uni cars may overflow into the general pool.
module parking_ctrl_sched #(
  parameter int CNT_W          = 16,
  parameter int TIME_W         = 12,
  parameter int TOTAL_CAP      = 700,
  parameter int UNI_CAP_DAY    = 500,
  parameter int UNI_CAP_NIGHT  = 200,
  parameter int DAY_LEN        = 1440,
  parameter int TICKS_PER_STEP = 1,
  parameter int T_DAY_START    = 480,
  parameter int T_RAMP_START   = 780,
  parameter int T_DAY_END      = 960,
  parameter int RAMP_PERIOD    = 60,
  parameter int RAMP_STEP      = 50,
  parameter int ALLOW_OVERFLOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              car_entered,
  input  logic              is_uni_car_entered,
  input  logic              car_exited,
  input  logic              is_uni_car_exited,
  output logic              entry_ok,
  output logic              entry_rejected,
  output logic              exit_err,
  output logic [CNT_W-1:0]  uni_car_parked,
  output logic [CNT_W-1:0]  parked_car,
  output logic [CNT_W-1:0]  uni_vacated_space,
  output logic [CNT_W-1:0]  vacated_space,
  output logic              uni_is_vacated_space,
  output logic              is_vacated_space,
  output logic [CNT_W-1:0]  uni_capacity,
  output logic [TIME_W-1:0] clock_time
);

  localparam int PRE_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int EXT_W = CNT_W + 2;

  localparam logic [CNT_W-1:0]  TOTAL_C      = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0]  CAP_DAY      = CNT_W'(UNI_CAP_DAY);
  localparam logic [CNT_W-1:0]  CAP_NIGHT    = CNT_W'(UNI_CAP_NIGHT);
  localparam logic [CNT_W-1:0]  RAMP_STEP_C  = CNT_W'(RAMP_STEP);
  localparam logic [TIME_W-1:0] T_LAST       = TIME_W'(DAY_LEN - 1);
  localparam logic [TIME_W-1:0] T_DAY_S      = TIME_W'(T_DAY_START);
  localparam logic [TIME_W-1:0] T_RAMP_S     = TIME_W'(T_RAMP_START);
  localparam logic [TIME_W-1:0] T_DAY_E      = TIME_W'(T_DAY_END);
  localparam logic [TIME_W-1:0] RAMP_LAST    = TIME_W'(RAMP_PERIOD - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST     = PRE_W'(TICKS_PER_STEP - 1);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [CNT_W-1:0]  cap_q, cap_d;
  logic [CNT_W-1:0]  uni_in_uni_q, uni_in_uni_d;
  logic [CNT_W-1:0]  uni_in_gen_q, uni_in_gen_d;
  logic [CNT_W-1:0]  gen_cnt_q, gen_cnt_d;
  logic              entry_ok_q, entry_ok_d;
  logic              entry_rej_q, entry_rej_d;
  logic              exit_err_q, exit_err_d;
  logic [CNT_W-1:0]  uni_vac_q, uni_vac_d;
  logic [CNT_W-1:0]  vac_q, vac_d;

  logic              step;
  logic [CNT_W-1:0]  uu_x, ug_x, gc_x;

  function automatic logic [CNT_W-1:0] ramp_dec(input logic [CNT_W-1:0] c);
    if ({1'b0, c} < ({1'b0, CAP_NIGHT} + {1'b0, RAMP_STEP_C}))
      return CAP_NIGHT;
    else
      return c - RAMP_STEP_C;
  endfunction

  function automatic logic [CNT_W-1:0] uni_space(input logic [CNT_W-1:0] cap,
                                                 input logic [CNT_W-1:0] uu);
    return (cap > uu) ? (cap - uu) : '0;
  endfunction

  // Uni cars beyond the current share keep their spaces and are charged to the general pool.
  function automatic logic [CNT_W-1:0] gen_space(input logic [CNT_W-1:0] cap,
                                                 input logic [CNT_W-1:0] uu,
                                                 input logic [CNT_W-1:0] ug,
                                                 input logic [CNT_W-1:0] gc);
    logic [EXT_W-1:0] gen_cap;
    logic [EXT_W-1:0] excess;
    logic [EXT_W-1:0] used;
    gen_cap = (TOTAL_C > cap) ? EXT_W'(TOTAL_C - cap) : '0;
    excess  = (uu > cap) ? EXT_W'(uu - cap) : '0;
    used    = EXT_W'(gc) + EXT_W'(ug) + excess;
    return (gen_cap > used) ? CNT_W'(gen_cap - used) : '0;
  endfunction

  always_comb begin
    presc_d    = presc_q;
    time_d     = time_q;
    ramp_cnt_d = ramp_cnt_q;
    cap_d      = cap_q;
    step       = 1'b0;
    if (start) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        step    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    // The ramp is tracked incrementally: ramp_cnt_q is the step offset within the current period.
    if (step) begin
      time_d = (time_q == T_LAST) ? '0 : time_q + 1'b1;
      if (time_d < T_DAY_S || time_d >= T_DAY_E) begin
        cap_d      = CAP_NIGHT;
        ramp_cnt_d = '0;
      end else if (time_d < T_RAMP_S) begin
        cap_d      = CAP_DAY;
        ramp_cnt_d = '0;
      end else if (time_d == T_RAMP_S) begin
        cap_d      = ramp_dec(CAP_DAY);
        ramp_cnt_d = '0;
      end else if (ramp_cnt_q == RAMP_LAST) begin
        cap_d      = ramp_dec(cap_q);
        ramp_cnt_d = '0;
      end else begin
        ramp_cnt_d = ramp_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    uu_x         = uni_in_uni_q;
    ug_x         = uni_in_gen_q;
    gc_x         = gen_cnt_q;
    uni_in_uni_d = uni_in_uni_q;
    uni_in_gen_d = uni_in_gen_q;
    gen_cnt_d    = gen_cnt_q;
    entry_ok_d   = 1'b0;
    entry_rej_d  = 1'b0;
    exit_err_d   = 1'b0;
    if (start && car_exited) begin
      if (is_uni_car_exited) begin
        if (uni_in_gen_q != '0)      ug_x = uni_in_gen_q - 1'b1;
        else if (uni_in_uni_q != '0) uu_x = uni_in_uni_q - 1'b1;
        else                         exit_err_d = 1'b1;
      end else begin
        if (gen_cnt_q != '0) gc_x = gen_cnt_q - 1'b1;
        else                 exit_err_d = 1'b1;
      end
    end
    uni_in_uni_d = uu_x;
    uni_in_gen_d = ug_x;
    gen_cnt_d    = gc_x;
    // Entry is judged against the post-exit counts so a full lot can swap a car in the same cycle.
    if (start && car_entered) begin
      if (is_uni_car_entered) begin
        if (uni_space(cap_q, uu_x) != '0) begin
          uni_in_uni_d = uu_x + 1'b1;
          entry_ok_d   = 1'b1;
        end else if ((ALLOW_OVERFLOW != 0) && (gen_space(cap_q, uu_x, ug_x, gc_x) != '0)) begin
          uni_in_gen_d = ug_x + 1'b1;
          entry_ok_d   = 1'b1;
        end else begin
          entry_rej_d  = 1'b1;
        end
      end else begin
        if (gen_space(cap_q, uu_x, ug_x, gc_x) != '0) begin
          gen_cnt_d    = gc_x + 1'b1;
          entry_ok_d   = 1'b1;
        end else begin
          entry_rej_d  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    uni_vac_d = uni_space(cap_d, uni_in_uni_d);
    vac_d     = gen_space(cap_d, uni_in_uni_d, uni_in_gen_d, gen_cnt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      time_q       <= '0;
      ramp_cnt_q   <= '0;
      cap_q        <= CAP_NIGHT;
      uni_in_uni_q <= '0;
      uni_in_gen_q <= '0;
      gen_cnt_q    <= '0;
      entry_ok_q   <= 1'b0;
      entry_rej_q  <= 1'b0;
      exit_err_q   <= 1'b0;
      uni_vac_q    <= '0;
      vac_q        <= '0;
    end else begin
      presc_q      <= presc_d;
      time_q       <= time_d;
      ramp_cnt_q   <= ramp_cnt_d;
      cap_q        <= cap_d;
      uni_in_uni_q <= uni_in_uni_d;
      uni_in_gen_q <= uni_in_gen_d;
      gen_cnt_q    <= gen_cnt_d;
      entry_ok_q   <= entry_ok_d;
      entry_rej_q  <= entry_rej_d;
      exit_err_q   <= exit_err_d;
      uni_vac_q    <= uni_vac_d;
      vac_q        <= vac_d;
    end
  end

  assign entry_ok             = entry_ok_q;
  assign entry_rejected       = entry_rej_q;
  assign exit_err             = exit_err_q;
  assign uni_car_parked       = uni_in_uni_q + uni_in_gen_q;
  assign parked_car           = gen_cnt_q;
  assign uni_vacated_space    = uni_vac_q;
  assign vacated_space        = vac_q;
  assign uni_is_vacated_space = (uni_vac_q != '0);
  assign is_vacated_space     = (vac_q != '0);
  assign uni_capacity         = cap_q;
  assign clock_time           = time_q;

endmodule

// File: tb/tb_parking_ctrl_sched.sv
// Directed-vector bench for parking_ctrl_sched using a small lot and a 20-step day.
module tb_parking_ctrl_sched;

   logic        clk;
   logic        rst;
   logic        start;
   logic        car_entered;
   logic        is_uni_car_entered;
   logic        car_exited;
   logic        is_uni_car_exited;
   logic        entry_ok;
   logic        entry_rejected;
   logic        exit_err;
   logic [15:0] uni_car_parked;
   logic [15:0] parked_car;
   logic [15:0] uni_vacated_space;
   logic [15:0] vacated_space;
   logic        uni_is_vacated_space;
   logic        is_vacated_space;
   logic [15:0] uni_capacity;
   logic [11:0] clock_time;

   int compareCount = 0;
   int failCount    = 0;

   parking_ctrl_sched #(
      .CNT_W(16), .TIME_W(12), .TOTAL_CAP(8), .UNI_CAP_DAY(5), .UNI_CAP_NIGHT(2),
      .DAY_LEN(20), .TICKS_PER_STEP(2), .T_DAY_START(4), .T_RAMP_START(8),
      .T_DAY_END(14), .RAMP_PERIOD(2), .RAMP_STEP(1), .ALLOW_OVERFLOW(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
      .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
      .entry_ok(entry_ok), .entry_rejected(entry_rejected), .exit_err(exit_err),
      .uni_car_parked(uni_car_parked), .parked_car(parked_car),
      .uni_vacated_space(uni_vacated_space), .vacated_space(vacated_space),
      .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
      .uni_capacity(uni_capacity), .clock_time(clock_time)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scheduled uni share written straight from the closed-form schedule
   function automatic int expCap(input int t);
      int c;
      if (t < 4 || t >= 14) return 2;
      if (t < 8) return 5;
      c = 5 - ((t - 8) / 2 + 1);
      return (c < 2) ? 2 : c;
   endfunction

   // Counts one comparison and reports it when observed and expected differ
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Advances one clock and parks the sampling point 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of gate events, then clears the event pulses
   task automatic applyStimulus(input logic en, input logic ent, input logic uniIn,
                                input logic ext, input logic uniOut);
      start              = en;
      car_entered        = ent;
      is_uni_car_entered = uniIn;
      car_exited         = ext;
      is_uni_car_exited  = uniOut;
      tick();
      car_entered        = 1'b0;
      is_uni_car_entered = 1'b0;
      car_exited         = 1'b0;
      is_uni_car_exited  = 1'b0;
   endtask

   // Full reset followed by one idle edge so the space outputs are populated
   task automatic doReset();
      start = 1'b0;
      rst   = 1'b1;
      tick();
      rst   = 1'b0;
      tick();
   endtask

   // Directed sequence covering schedule, overflow, full lot, ramp excess, errors and reset
   initial begin
      rst = 1'b1;
      start = 1'b0;
      car_entered = 1'b0;
      is_uni_car_entered = 1'b0;
      car_exited = 1'b0;
      is_uni_car_exited = 1'b0;
      tick();
      tick();
      checkOutput("rst_uni_parked", 32'(uni_car_parked), 32'd0);
      checkOutput("rst_parked", 32'(parked_car), 32'd0);
      checkOutput("rst_vacated", 32'(vacated_space), 32'd0);
      checkOutput("rst_uni_vacated", 32'(uni_vacated_space), 32'd0);
      checkOutput("rst_time", 32'(clock_time), 32'd0);
      checkOutput("rst_cap", 32'(uni_capacity), 32'd2);
      rst = 1'b0;
      tick();
      checkOutput("post_rst_uni_vac", 32'(uni_vacated_space), 32'd2);
      checkOutput("post_rst_vac", 32'(vacated_space), 32'd6);

      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("sched_time", 32'(clock_time), 32'((k / 2) % 20));
         checkOutput("sched_cap", 32'(uni_capacity), 32'(expCap((k / 2) % 20)));
      end
      checkOutput("sched_vac", 32'(vacated_space), 32'd6);

      doReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("uni1_ok", 32'(entry_ok), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("uni2_ok", 32'(entry_ok), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("uni3_ovf_ok", 32'(entry_ok), 32'd1);
      checkOutput("uni3_rej", 32'(entry_rejected), 32'd0);
      checkOutput("uni3_parked", 32'(uni_car_parked), 32'd3);
      checkOutput("uni3_uni_vac", 32'(uni_vacated_space), 32'd0);
      checkOutput("uni3_vac", 32'(vacated_space), 32'd5);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("uniexit_pulse", 32'(entry_ok), 32'd0);
      checkOutput("uniexit_parked", 32'(uni_car_parked), 32'd2);
      checkOutput("uniexit_vac", 32'(vacated_space), 32'd6);
      checkOutput("uniexit_uni_vac", 32'(uni_vacated_space), 32'd0);

      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("gen1_vac", 32'(vacated_space), 32'd5);
      for (int i = 2; i <= 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("gen6_parked", 32'(parked_car), 32'd6);
      checkOutput("gen6_is_vac", 32'(is_vacated_space), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("gen7_rej", 32'(entry_rejected), 32'd1);
      checkOutput("gen7_ok", 32'(entry_ok), 32'd0);
      checkOutput("gen7_parked", 32'(parked_car), 32'd6);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("swap_ok", 32'(entry_ok), 32'd1);
      checkOutput("swap_rej", 32'(entry_rejected), 32'd0);
      checkOutput("swap_err", 32'(exit_err), 32'd0);
      checkOutput("swap_parked", 32'(parked_car), 32'd6);

      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("day_time", 32'(clock_time), 32'd4);
      checkOutput("day_cap", 32'(uni_capacity), 32'd5);
      checkOutput("day_vac", 32'(vacated_space), 32'd3);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("day5_parked", 32'(uni_car_parked), 32'd5);
      checkOutput("day5_uni_vac", 32'(uni_vacated_space), 32'd0);
      for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("ramp_time", 32'(clock_time), 32'd12);
      checkOutput("ramp_cap", 32'(uni_capacity), 32'd2);
      checkOutput("ramp_uni_vac", 32'(uni_vacated_space), 32'd0);
      checkOutput("ramp_vac", 32'(vacated_space), 32'd3);
      checkOutput("ramp_no_evict", 32'(uni_car_parked), 32'd5);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("ramp_ovf_ok", 32'(entry_ok), 32'd1);
      checkOutput("ramp_ovf_vac", 32'(vacated_space), 32'd2);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_pulse", 32'(entry_ok), 32'd0);
      checkOutput("async_uni_parked", 32'(uni_car_parked), 32'd0);
      checkOutput("async_parked", 32'(parked_car), 32'd0);
      checkOutput("async_vac", 32'(vacated_space), 32'd0);
      checkOutput("async_uni_vac", 32'(uni_vacated_space), 32'd0);
      checkOutput("async_time", 32'(clock_time), 32'd0);
      start = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      checkOutput("release_cap", 32'(uni_capacity), 32'd2);
      checkOutput("release_vac", 32'(vacated_space), 32'd6);
      checkOutput("release_uni_vac", 32'(uni_vacated_space), 32'd2);

      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("err_uni", 32'(exit_err), 32'd1);
      checkOutput("err_uni_cnt", 32'(uni_car_parked), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("err_gen", 32'(exit_err), 32'd1);
      checkOutput("err_gen_cnt", 32'(parked_car), 32'd0);
      checkOutput("err_time", 32'(clock_time), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("halt_ok", 32'(entry_ok), 32'd0);
      checkOutput("halt_rej", 32'(entry_rejected), 32'd0);
      checkOutput("halt_err", 32'(exit_err), 32'd0);
      checkOutput("halt_uni_cnt", 32'(uni_car_parked), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("halt_gen_cnt", 32'(parked_car), 32'd0);
      checkOutput("halt_time", 32'(clock_time), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
